// File: rtl/spi_vip_slave_core.sv
// Clock-oversampled SPI slave endpoint: synchronized pin sampling,
// MSB-first word deserializer and a one-entry buffered MISO serializer.
module spi_vip_slave_core #(
   parameter bit          CPOL              = 1'b0,
   parameter bit          CPHA              = 1'b0,
   parameter bit          INV_CS            = 1'b0,
   parameter int          DATA_DLENGTH      = 16,
   parameter int          SLAVE_TIN         = 0,
   parameter int          SLAVE_TOUT        = 0,
   parameter int          CS_TO_MISO        = 0,
   parameter logic [31:0] DEFAULT_MISO_DATA = 32'hCAFE
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    spi_sclk,
   input  logic                    spi_mosi,
   input  logic                    spi_cs,
   output logic                    spi_miso,
   output logic                    spi_miso_en,
   input  logic [DATA_DLENGTH-1:0] tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic [DATA_DLENGTH-1:0] rx_data,
   output logic                    rx_valid,
   output logic                    busy
);

   localparam int W = DATA_DLENGTH;
   localparam int D = 2 + SLAVE_TIN;
   localparam logic [W-1:0] DFLT = DEFAULT_MISO_DATA[W-1:0];

   typedef enum logic [1:0] {
      ST_ARM,
      ST_IDLE,
      ST_BUSY
   } state_t;

   state_t state, state_nx;

   // bit 3 marks a stage holding a real pin sample rather than reset fill
   logic [3:0] pipe [D];
   logic       in_vld, cs_s, mosi_s, sclk_s, sclk_q, cs_act;
   logic       rise, fall, samp, shft, start, stop, last, load;

   logic [5:0]   cnt;
   logic [7:0]   dly;
   logic [W-1:0] tx_sr, rx_sr, buf_data, next_word;
   logic         buf_full, miso_r, en_r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < D; i++) pipe[i] <= '0;
         sclk_q <= 1'b0;
      end else begin
         pipe[0] <= {1'b1, spi_cs, spi_mosi, spi_sclk};
         for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
         sclk_q <= sclk_s;
      end
   end

   assign in_vld = pipe[D-1][3];
   assign cs_s   = pipe[D-1][2];
   assign mosi_s = pipe[D-1][1];
   assign sclk_s = pipe[D-1][0];
   assign cs_act = INV_CS ? cs_s : ~cs_s;

   assign rise = sclk_s & ~sclk_q;
   assign fall = ~sclk_s & sclk_q;
   assign samp = (CPOL ^ CPHA) ? fall : rise;
   assign shft = (CPOL ^ CPHA) ? rise : fall;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_ARM;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      stop     = 1'b0;
      unique case (state)
         ST_ARM: begin
            if (in_vld && !cs_act) state_nx = ST_IDLE;
         end
         ST_IDLE: begin
            if (cs_act) begin
               state_nx = ST_BUSY;
               start    = 1'b1;
            end
         end
         ST_BUSY: begin
            if (!cs_act) begin
               state_nx = ST_IDLE;
               stop     = 1'b1;
            end
         end
         default: state_nx = ST_ARM;
      endcase
   end

   assign last      = (cnt == 6'(W - 1));
   assign next_word = buf_full ? buf_data : DFLT;
   assign load      = start ||
                      ((state == ST_BUSY) && !stop && samp && last);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt      <= '0;
         dly      <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         buf_data <= '0;
         buf_full <= 1'b0;
         miso_r   <= 1'b0;
         en_r     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (tx_valid && !buf_full) begin
            buf_full <= 1'b1;
            buf_data <= tx_data;
         end
         if (load && buf_full) buf_full <= 1'b0;
         if (start) begin
            cnt   <= '0;
            rx_sr <= '0;
            if (!CPHA && CS_TO_MISO == 0) begin
               miso_r <= next_word[W-1];
               tx_sr  <= next_word << 1;
               en_r   <= 1'b1;
            end else begin
               tx_sr <= next_word;
               dly   <= CPHA ? 8'd0 : 8'(CS_TO_MISO);
               en_r  <= CPHA;
            end
         end else if (stop) begin
            cnt    <= '0;
            dly    <= '0;
            en_r   <= 1'b0;
            miso_r <= 1'b0;
         end else if (state == ST_BUSY) begin
            if (dly != 8'd0) begin
               dly <= dly - 8'd1;
               if (dly == 8'd1) begin
                  miso_r <= tx_sr[W-1];
                  tx_sr  <= tx_sr << 1;
                  en_r   <= 1'b1;
               end
            end
            if (samp) begin
               rx_sr <= {rx_sr[W-2:0], mosi_s};
               if (last) begin
                  cnt      <= '0;
                  rx_data  <= {rx_sr[W-2:0], mosi_s};
                  rx_valid <= 1'b1;
                  tx_sr    <= next_word;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end else if (shft) begin
               miso_r <= tx_sr[W-1];
               tx_sr  <= tx_sr << 1;
            end
         end
      end
   end

   generate
      if (SLAVE_TOUT == 0) begin : g_out_direct
         assign spi_miso    = miso_r;
         assign spi_miso_en = en_r;
      end else begin : g_out_delay
         logic [1:0] opipe [SLAVE_TOUT];
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               for (int i = 0; i < SLAVE_TOUT; i++) opipe[i] <= '0;
            end else begin
               opipe[0] <= {en_r, miso_r};
               for (int i = 1; i < SLAVE_TOUT; i++) opipe[i] <= opipe[i-1];
            end
         end
         assign spi_miso    = opipe[SLAVE_TOUT-1][0];
         assign spi_miso_en = opipe[SLAVE_TOUT-1][1];
      end
   endgenerate

   assign tx_ready = ~buf_full;
   assign busy     = (state == ST_BUSY);

endmodule

// File: tb/tb_spi_vip_slave_core.sv
// Directed bench: four slave instances (mode 0, mode 3, active-high CS,
// extra in/out delay) driven by a simple bit-banged master.
module tb_spi_vip_slave_core;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mosi;
   logic        sclk0  [4];
   logic        cs_on  [4];
   logic        sclk_p [4];
   logic        cs_p   [4];
   logic [15:0] txd    [4];
   logic        txv    [4];
   logic        miso   [4];
   logic        en     [4];
   logic        txr    [4];
   logic [15:0] rxd    [4];
   logic        rxv    [4];
   logic        bsy    [4];
   int          rxcnt  [4];

   int nerr = 0;
   int nchk = 0;
   int c0;
   logic [15:0] rd;

   always #5 clk = ~clk;

   assign sclk_p[0] = sclk0[0];
   assign sclk_p[1] = ~sclk0[1];
   assign sclk_p[2] = sclk0[2];
   assign sclk_p[3] = sclk0[3];
   assign cs_p[0]   = ~cs_on[0];
   assign cs_p[1]   = ~cs_on[1];
   assign cs_p[2]   = cs_on[2];
   assign cs_p[3]   = ~cs_on[3];

   spi_vip_slave_core u_m0 (
      .clk(clk), .resetn(resetn),
      .spi_sclk(sclk_p[0]), .spi_mosi(mosi), .spi_cs(cs_p[0]),
      .spi_miso(miso[0]), .spi_miso_en(en[0]),
      .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
      .rx_data(rxd[0]), .rx_valid(rxv[0]), .busy(bsy[0]));

   spi_vip_slave_core #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
      .clk(clk), .resetn(resetn),
      .spi_sclk(sclk_p[1]), .spi_mosi(mosi), .spi_cs(cs_p[1]),
      .spi_miso(miso[1]), .spi_miso_en(en[1]),
      .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(txr[1]),
      .rx_data(rxd[1]), .rx_valid(rxv[1]), .busy(bsy[1]));

   spi_vip_slave_core #(.INV_CS(1'b1)) u_inv (
      .clk(clk), .resetn(resetn),
      .spi_sclk(sclk_p[2]), .spi_mosi(mosi), .spi_cs(cs_p[2]),
      .spi_miso(miso[2]), .spi_miso_en(en[2]),
      .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(txr[2]),
      .rx_data(rxd[2]), .rx_valid(rxv[2]), .busy(bsy[2]));

   spi_vip_slave_core #(.SLAVE_TIN(2), .SLAVE_TOUT(1)) u_dly (
      .clk(clk), .resetn(resetn),
      .spi_sclk(sclk_p[3]), .spi_mosi(mosi), .spi_cs(cs_p[3]),
      .spi_miso(miso[3]), .spi_miso_en(en[3]),
      .tx_data(txd[3]), .tx_valid(txv[3]), .tx_ready(txr[3]),
      .rx_data(rxd[3]), .rx_valid(rxv[3]), .busy(bsy[3]));

   initial for (int i = 0; i < 4; i++) rxcnt[i] = 0;

   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (rxv[i]) rxcnt[i] <= rxcnt[i] + 1;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_set(input int s, input logic on);
      @(negedge clk);
      cs_on[s] = on;
   endtask

   task automatic frame_open(input int s);
      cs_set(s, 1'b1);
      half();
   endtask

   task automatic push(input int s, input logic [15:0] w);
      @(negedge clk);
      txd[s] = w;
      txv[s] = 1'b1;
      @(negedge clk);
      txv[s] = 1'b0;
   endtask

   task automatic xfer(input int s, input bit cpha, input logic [15:0] w,
                       input int nbits, output logic [15:0] r);
      r = '0;
      for (int i = 15; i > 15 - nbits; i--) begin
         if (!cpha) begin
            mosi = w[i];
            half();
            r = {r[14:0], miso[s]};
            sclk0[s] = 1'b1;
            half();
            sclk0[s] = 1'b0;
         end else begin
            sclk0[s] = 1'b1;
            mosi = w[i];
            half();
            r = {r[14:0], miso[s]};
            sclk0[s] = 1'b0;
            half();
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      mosi   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sclk0[i] = 1'b0;
         cs_on[i] = 1'b0;
         txd[i]   = '0;
         txv[i]   = 1'b0;
      end
      repeat (4) @(negedge clk);
      check("rst_miso", miso[0], 0);
      check("rst_en", en[0], 0);
      check("rst_txr", txr[0], 1);
      check("rst_rxv", rxv[0], 0);
      check("rst_rxd", rxd[0], 0);
      check("rst_busy", bsy[0], 0);
      resetn = 1'b1;
      repeat (10) @(negedge clk);

      c0 = rxcnt[0];
      frame_open(0);
      check("m0_busy", bsy[0], 1);
      check("m0_en", en[0], 1);
      xfer(0, 1'b0, 16'hA5C3, 16, rd);
      check("m0_rxcnt", rxcnt[0], c0 + 1);
      check("m0_rxd", rxd[0], 16'hA5C3);
      check("m0_miso", rd, 16'hCAFE);
      cs_set(0, 1'b0);
      repeat (5) @(negedge clk);
      check("m0_idle_busy", bsy[0], 0);
      check("m0_idle_en", en[0], 0);

      push(0, 16'h1234);
      check("tx_full", txr[0], 0);
      c0 = rxcnt[0];
      frame_open(0);
      check("tx_freed", txr[0], 1);
      xfer(0, 1'b0, 16'h0F0F, 16, rd);
      check("tx_w1", rd, 16'h1234);
      check("tx_rx1", rxd[0], 16'h0F0F);
      xfer(0, 1'b0, 16'hF0F0, 16, rd);
      check("tx_w2", rd, 16'hCAFE);
      check("tx_rx2", rxd[0], 16'hF0F0);
      check("tx_rxcnt", rxcnt[0], c0 + 2);
      cs_set(0, 1'b0);
      repeat (5) @(negedge clk);

      c0 = rxcnt[1];
      frame_open(1);
      check("m3_en", en[1], 1);
      fork
         xfer(1, 1'b1, 16'h0001, 16, rd);
         begin
            repeat (40) @(negedge clk);
            push(1, 16'hBEEF);
         end
      join
      check("m3_w1", rd, 16'hCAFE);
      check("m3_rx1", rxd[1], 16'h0001);
      check("m3_txr", txr[1], 1);
      xfer(1, 1'b1, 16'h8000, 16, rd);
      check("m3_w2", rd, 16'hBEEF);
      check("m3_rx2", rxd[1], 16'h8000);
      check("m3_rxcnt", rxcnt[1], c0 + 2);
      cs_set(1, 1'b0);
      repeat (5) @(negedge clk);

      frame_open(2);
      check("inv_busy", bsy[2], cs_p[2]);
      xfer(2, 1'b0, 16'h5A5A, 16, rd);
      check("inv_rxd", rxd[2], 16'h5A5A);
      cs_set(2, 1'b0);
      repeat (5) @(negedge clk);
      check("inv_idle", bsy[2], cs_p[2]);

      c0 = rxcnt[0];
      frame_open(0);
      xfer(0, 1'b0, 16'hFFFF, 7, rd);
      cs_set(0, 1'b0);
      repeat (3) @(negedge clk);
      check("part_en", en[0], 0);
      check("part_busy", bsy[0], 0);
      repeat (10) @(negedge clk);
      check("part_rxcnt", rxcnt[0], c0);
      frame_open(0);
      xfer(0, 1'b0, 16'h3C96, 16, rd);
      check("part_next_rx", rxd[0], 16'h3C96);
      check("part_next_tx", rd, 16'hCAFE);
      check("part_next_cnt", rxcnt[0], c0 + 1);
      cs_set(0, 1'b0);
      repeat (5) @(negedge clk);

      c0 = rxcnt[0];
      frame_open(0);
      xfer(0, 1'b0, 16'h1111, 5, rd);
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("mrst_busy", bsy[0], 0);
      check("mrst_en", en[0], 0);
      check("mrst_txr", txr[0], 1);
      check("mrst_rxd", rxd[0], 0);
      resetn = 1'b1;
      xfer(0, 1'b0, 16'h1111, 11, rd);
      check("mrst_ign_busy", bsy[0], 0);
      check("mrst_ign_en", en[0], 0);
      check("mrst_ign_cnt", rxcnt[0], c0);
      cs_set(0, 1'b0);
      repeat (10) @(negedge clk);
      frame_open(0);
      xfer(0, 1'b0, 16'h0FF0, 16, rd);
      check("mrst_next_rx", rxd[0], 16'h0FF0);
      check("mrst_next_tx", rd, 16'hCAFE);
      check("mrst_next_cnt", rxcnt[0], c0 + 1);
      cs_set(0, 1'b0);
      repeat (5) @(negedge clk);

      frame_open(3);
      check("lat_msb", miso[3], 1);
      sclk0[3] = 1'b1;
      half();
      sclk0[3] = 1'b0;
      half();
      sclk0[3] = 1'b1;
      half();
      sclk0[3] = 1'b0;
      repeat (5) @(negedge clk);
      check("lat_before", miso[3], 1);
      @(negedge clk);
      check("lat_at", miso[3], 0);
      half();
      cs_set(3, 1'b0);
      repeat (10) @(negedge clk);
      check("lat_idle_en", en[3], 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
